mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port arbiter between the instruction cache and the load/store buffer (LSB) on one side and the byte-wide RAM/IO bus on the other.
- Serialises each 1/2/4-byte access into byte transfers and assembles 32-bit results little-endian.
- Returns a one-cycle done pulse to the requester.
- Upstream of the instruction cache: it serves the cache's miss requests (ins_req/ins_addr) and delivers the fetched word.

Parameters:
- ADDR_W, 32, width of every address port and mem_a.
- IO_TAG, 2'b11, value of addr[17:16] that marks an IO-space access.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low freezes all state.
- jp_wrong  in  1  branch mispredict flush.
- ins_req  in  1  instruction-fetch request, level; held until done.
- ins_addr  in  ADDR_W  fetch address, stable while ins_req is high.
- ins_done  out  1  one-cycle pulse: ins valid.
- ins  out  32  fetched word.
- ls_req  in  1  LSB request, level; held until done.
- ls_wr  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  byte address.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- ls_wdata  in  32  store data, low bytes used.
- ls_done  out  1  one-cycle pulse: access complete.
- ls_rdata  out  32  load data, zero-extended; the LSB sign-extends.
- mem_din  in  8  RAM read byte, valid one cycle after the address is sampled.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_W  RAM byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0.
- rdy low: no state change, no accept. mem_wr keeps its registered value; it is never newly asserted.
- States:
  - IDLE: accept a request.
  - READ: issue addresses and collect bytes.
  - WRITE: issue bytes.
  - DONE: single bubble cycle in which done is high.
- Accept rules, in IDLE only:
  - ls_req has priority over ins_req.
  - No accept in a cycle where jp_wrong is high.
  - No accept in the DONE cycle. This is needed because the requester still holds req during the done cycle, before its cache/queue has updated.
  - A store to IO (ls_addr[17:16] == IO_TAG) while io_buffer_full is high is not accepted; the controller stays IDLE.
- N = bytes of the access (1, 2 or 4; fetch is always 4). Accept edge = E0.
- READ timing:
  - mem_a <= addr+i registered at edge Ei, for i = 0..N-1.
  - Byte i is captured from mem_din at edge E(i+2) into bits [8i+7:8i].
  - At E(N+1): result registered to ins/ls_rdata, done <= 1, state <= DONE.
  - Latency from accept to done-high: word 5 cycles, byte 2 cycles.
- WRITE timing:
  - mem_a <= addr+i, mem_dout <= wdata[8i+7:8i], mem_wr <= 1 at Ei.
  - At EN: mem_wr <= 0, ls_done <= 1, state <= DONE.
  - Word store: done after E4. Byte store: done after E1.
- DONE: done outputs clear at the next edge; state <= IDLE.
- ins/ls_rdata hold their value after done; they are only meaningful while done is high.
- Address arithmetic: addr+i wraps modulo 2^ADDR_W. No alignment checks.
- jp_wrong:
  - During READ (fetch or load): abort at the next edge to IDLE. No done pulse, mem_wr stays 0, partial data discarded.
  - During WRITE: ignored; committed stores always complete.
  - During DONE: done still pulses; the requester discards it.
- Simultaneous ins_req and ls_req in IDLE: the LSB access is served first. The fetch is accepted on the first legal IDLE edge after the LSB's DONE cycle.
- mem_wr is 0 in every cycle except the N cycles of a WRITE.
- Asynchronous rst mid-access: immediate return to reset values; mem_wr drops without waiting for a clock.

Decomposition:
- Shared defines header:
  - state encodings IDLE/READ/WRITE/DONE;
  - size codes SZ_B/SZ_H/SZ_W;
  - IO_TAG and the IO address bit range [17:16];
  - True/False.
- No sub-module: the FSM, byte counter and assembly register stay in one module.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00; ins_req with ins_addr = 0x100 -> ins_done high exactly 5 cycles after accept, ins = 0x00100513, then ins_done low; no re-accept in the done cycle.
- Load byte and half: ls_size = 0 at 0x201 containing 0xF3 -> ls_rdata = 0x000000F3 after 2 cycles; ls_size = 1 at 0x200 -> 0x0000F3xx little-endian.
- Store word: ls_wr = 1, ls_addr = 0x300, wdata = 0xDEADBEEF -> mem_wr high 4 cycles with (0x300,EF), (0x301,BE), (0x302,AD), (0x303,DE); ls_done after E4; mem_wr = 0 afterwards.
- Priority: ins_req and ls_req (load) raised in the same cycle -> LSB load completes first; fetch starts after one DONE bubble, and its ins_done arrives 5 cycles after that accept.
- Flush: jp_wrong pulsed 2 cycles into a fetch -> no ins_done; state IDLE next cycle. jp_wrong during a word store -> store completes, all 4 bytes written.
- IO stall and rdy: store to 0x30000 with io_buffer_full = 1 for 3 cycles -> no mem_wr, accepted the edge after it drops. rdy low 2 cycles mid-fetch -> done delayed by exactly 2 cycles, data unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM/IO memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [1:0]  DEF_IO_TAG = 2'b11;
   localparam int unsigned IO_HI      = 17;
   localparam int unsigned IO_LO      = 16;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   // Byte counter must reach N+1 = 5 for a word read.
   localparam int unsigned CNT_W = 3;

   // Size code 3 is illegal and serviced as a word.
   function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
      case (size)
         SZ_B:    return CNT_W'(1);
         SZ_H:    return CNT_W'(2);
         SZ_W:    return CNT_W'(4);
         default: return CNT_W'(4);
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction-fetch and LSB requests onto the byte-wide RAM/IO bus,
// serialising 1/2/4-byte accesses and assembling little-endian read words.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter logic [1:0]  IO_TAG = DEF_IO_TAG
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              jp_wrong,
   input  logic              ins_req,
   input  logic [ADDR_W-1:0] ins_addr,
   output logic              ins_done,
   output logic [31:0]       ins,
   input  logic              ls_req,
   input  logic              ls_wr,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [1:0]        ls_size,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [CNT_W-1:0]    nbytes, nbytes_n;
   logic [ADDR_W-1:0]   base, base_n;
   logic                for_ins, for_ins_n;
   logic [31:0]         wbuf, wbuf_n;
   logic [31:0]         acc, acc_n;

   logic [ADDR_W-1:0]   mem_a_n;
   logic [7:0]          mem_dout_n;
   logic                mem_wr_n;
   logic [31:0]         ins_n, ls_rdata_n;
   logic                ins_done_n, ls_done_n;

   logic                io_stall;
   logic [CNT_W-1:0]    rd_last;
   logic [1:0]          slot;

   // A store into IO space cannot start while the UART buffer is full.
   assign io_stall = ls_wr && (ls_addr[IO_HI:IO_LO] == IO_TAG) && io_buffer_full;
   assign rd_last  = nbytes + CNT_W'(1);
   assign slot     = 2'(cnt - CNT_W'(2));

   // State and output registers; rdy low freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         nbytes   <= '0;
         base     <= '0;
         for_ins  <= FALSE;
         wbuf     <= '0;
         acc      <= '0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= FALSE;
         ins      <= '0;
         ins_done <= FALSE;
         ls_rdata <= '0;
         ls_done  <= FALSE;
      end else if (rdy) begin
         state    <= state_n;
         cnt      <= cnt_n;
         nbytes   <= nbytes_n;
         base     <= base_n;
         for_ins  <= for_ins_n;
         wbuf     <= wbuf_n;
         acc      <= acc_n;
         mem_a    <= mem_a_n;
         mem_dout <= mem_dout_n;
         mem_wr   <= mem_wr_n;
         ins      <= ins_n;
         ins_done <= ins_done_n;
         ls_rdata <= ls_rdata_n;
         ls_done  <= ls_done_n;
      end
   end

   // Next-state, address sequencing and byte assembly.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      nbytes_n   = nbytes;
      base_n     = base;
      for_ins_n  = for_ins;
      wbuf_n     = wbuf;
      acc_n      = acc;
      mem_a_n    = mem_a;
      mem_dout_n = mem_dout;
      mem_wr_n   = FALSE;
      ins_n      = ins;
      ins_done_n = FALSE;
      ls_rdata_n = ls_rdata;
      ls_done_n  = FALSE;

      case (state)
         IDLE: begin
            if (!jp_wrong) begin
               if (ls_req && !io_stall) begin
                  for_ins_n = FALSE;
                  base_n    = ls_addr;
                  nbytes_n  = size_bytes(ls_size);
                  cnt_n     = CNT_W'(1);
                  mem_a_n   = ls_addr;
                  acc_n     = '0;
                  if (ls_wr) begin
                     wbuf_n     = ls_wdata;
                     mem_dout_n = ls_wdata[7:0];
                     mem_wr_n   = TRUE;
                     state_n    = WRITE;
                  end else begin
                     state_n    = READ;
                  end
               end else if (!ls_req && ins_req) begin
                  for_ins_n = TRUE;
                  base_n    = ins_addr;
                  nbytes_n  = CNT_W'(4);
                  cnt_n     = CNT_W'(1);
                  mem_a_n   = ins_addr;
                  acc_n     = '0;
                  state_n   = READ;
               end
            end
         end

         READ: begin
            if (jp_wrong) begin
               // Flush drops the partial word without signalling done.
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt < nbytes) begin
                  mem_a_n = base + ADDR_W'(cnt);
               end
               // RAM returns byte i two edges after its address was issued.
               if (cnt >= CNT_W'(2)) begin
                  acc_n[{slot, 3'b000} +: 8] = mem_din;
               end
               if (cnt == rd_last) begin
                  cnt_n   = '0;
                  state_n = DONE;
                  if (for_ins) begin
                     ins_n      = acc_n;
                     ins_done_n = TRUE;
                  end else begin
                     ls_rdata_n = acc_n;
                     ls_done_n  = TRUE;
                  end
               end
            end
         end

         WRITE: begin
            // Committed stores run to completion regardless of jp_wrong.
            if (cnt < nbytes) begin
               mem_a_n    = base + ADDR_W'(cnt);
               mem_dout_n = wbuf[{cnt[1:0], 3'b000} +: 8];
               mem_wr_n   = TRUE;
               cnt_n      = cnt + CNT_W'(1);
            end else begin
               ls_done_n = TRUE;
               cnt_n     = '0;
               state_n   = DONE;
            end
         end

         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a byte-array memory model.
module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        jp_wrong;
   logic        ins_req;
   logic [31:0] ins_addr;
   logic        ins_done;
   logic [31:0] ins;
   logic        ls_req;
   logic        ls_wr;
   logic [31:0] ls_addr;
   logic [1:0]  ls_size;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   int checks;
   int errors;

   mem_ctrl #(.ADDR_W(32), .IO_TAG(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
      .ins_req(ins_req), .ins_addr(ins_addr), .ins_done(ins_done), .ins(ins),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
      .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte RAM on the same global ready as the controller.
   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   logic [7:0] ram   [logic [31:0]];
   logic [7:0] model [logic [31:0]];
   wr_t        wlog  [$];

   always @(posedge clk) begin
      if (rst) begin
         mem_din <= 8'h00;
      end else if (rdy) begin
         mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
         if (mem_wr) begin
            ram[mem_a] = mem_dout;
            wlog.push_back('{a: mem_a, d: mem_dout});
         end
      end
   end

   typedef struct {
      bit          is_ins;
      bit          wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } txn_t;

   function automatic txn_t mk(input bit is_ins, input bit wr, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp, input int lat);
      txn_t t;
      t.is_ins = is_ins; t.wr = wr; t.size = size; t.addr = addr;
      t.wdata = wdata; t.exp = exp; t.lat = lat;
      return t;
   endfunction

   function automatic int nbytes_of(input txn_t t);
      if (t.is_ins) return 4;
      case (t.size)
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
      logic [31:0] v;
      logic [31:0] ai;
      logic [7:0]  b;
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         b  = model.exists(ai) ? model[ai] : 8'h00;
         v  = v | ({24'h0, b} << (8 * i));
      end
      return v;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      ram[a]   = d;
      model[a] = d;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold req through the done cycle, then release and confirm the bus is quiet.
   task automatic settle(input string tag);
      int bad;
      step();
      chk({tag, "_done_clear"}, {30'h0, ins_done, ls_done}, 32'h0);
      ins_req = 1'b0;
      ls_req  = 1'b0;
      ls_wr   = 1'b0;
      bad = 0;
      repeat (6) begin
         step();
         if (ins_done || ls_done || mem_wr) bad++;
      end
      chk({tag, "_quiet"}, 32'(bad), 32'h0);
   endtask

   task automatic run_txn(input txn_t t, input int stall_at, input int stall_len,
                          input int jp_at, input bit rnd_rdy, input string tag);
      int          n, edges, wall, exp_edges, stray;
      bit          got;
      logic [31:0] sh, ai;
      n = nbytes_of(t);
      exp_edges = t.lat + 1;
      wlog.delete();
      if (t.is_ins) begin
         ins_req = 1'b1; ins_addr = t.addr;
      end else begin
         ls_req = 1'b1; ls_wr = t.wr; ls_addr = t.addr; ls_size = t.size; ls_wdata = t.wdata;
      end
      edges = 0; wall = 0; got = 1'b0; stray = 0;
      while (!got && wall < 100) begin
         if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
         else         rdy = !(wall >= stall_at && wall < stall_at + stall_len);
         jp_wrong = (wall == jp_at);
         @(posedge clk);
         if (rdy) edges++;
         wall++;
         #1;
         if (t.is_ins ? ins_done : ls_done) got = 1'b1;
         if (t.is_ins ? ls_done : ins_done) stray++;
      end
      rdy = 1'b1;
      jp_wrong = 1'b0;
      chk({tag, "_done_seen"}, 32'(got), 32'h1);
      chk({tag, "_stray_done"}, 32'(stray), 32'h0);
      if (got) begin
         chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
         if (!rnd_rdy) chk({tag, "_wall"}, 32'(wall), 32'(exp_edges + stall_len));
         if (!t.wr) chk({tag, "_data"}, t.is_ins ? ins : ls_rdata, t.exp);
      end
      chk({tag, "_wr_count"}, 32'(wlog.size()), t.wr ? 32'(n) : 32'h0);
      if (t.wr) begin
         for (int i = 0; i < n && i < wlog.size(); i++) begin
            ai = t.addr + 32'(i);
            sh = t.wdata >> (8 * i);
            chk({tag, "_wr_addr"}, wlog[i].a, ai);
            chk({tag, "_wr_byte"}, {24'h0, wlog[i].d}, {24'h0, sh[7:0]});
            model[ai] = sh[7:0];
         end
      end
      settle(tag);
   endtask

   txn_t tab [10];
   txn_t t;
   int   wall, bad, jp;
   bit   got, early;

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; io_buffer_full = 1'b0;
      ins_req = 1'b0; ins_addr = 32'h0; ls_req = 1'b0; ls_wr = 1'b0;
      ls_addr = 32'h0; ls_size = 2'd0; ls_wdata = 32'h0;

      poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
      poke(32'h200, 8'h7A); poke(32'h201, 8'hF3);
      poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22);
      poke(32'h0, 8'h33); poke(32'h1, 8'h44);

      //          ins   wr    size  addr            wdata          exp            lat
      tab[0] = mk(1'b1, 1'b0, 2'd2, 32'h100,        32'h0,         32'h0010_0513, 5);
      tab[1] = mk(1'b0, 1'b0, 2'd0, 32'h201,        32'h0,         32'h0000_00F3, 2);
      tab[2] = mk(1'b0, 1'b0, 2'd1, 32'h200,        32'h0,         32'h0000_F37A, 3);
      tab[3] = mk(1'b0, 1'b0, 2'd3, 32'h100,        32'h0,         32'h0010_0513, 5);
      tab[4] = mk(1'b0, 1'b1, 2'd2, 32'h300,        32'hDEAD_BEEF, 32'h0,         4);
      tab[5] = mk(1'b0, 1'b1, 2'd0, 32'h310,        32'h0000_00A5, 32'h0,         1);
      tab[6] = mk(1'b0, 1'b1, 2'd1, 32'h312,        32'h0000_BEEF, 32'h0,         2);
      tab[7] = mk(1'b0, 1'b0, 2'd2, 32'h300,        32'h0,         32'hDEAD_BEEF, 5);
      tab[8] = mk(1'b0, 1'b0, 2'd2, 32'h310,        32'h0,         32'hBEEF_00A5, 5);
      tab[9] = mk(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFE,  32'h0,         32'h4433_2211, 5);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ins_done", 32'(ins_done), 32'h0);
      chk("rst_ins", ins, 32'h0);
      chk("rst_ls_done", 32'(ls_done), 32'h0);
      chk("rst_ls_rdata", ls_rdata, 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
      chk("rst_mem_wr", 32'(mem_wr), 32'h0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 10; i++) run_txn(tab[i], 0, 0, -1, 1'b0, $sformatf("vec%0d", i));

      // Simultaneous requests: load first, fetch one DONE bubble later.
      ins_req = 1'b1; ins_addr = 32'h100;
      ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h300; ls_size = 2'd2;
      wall = 0; got = 1'b0; early = 1'b0;
      while (!got && wall < 50) begin
         step(); wall++;
         if (ls_done) got = 1'b1;
         if (ins_done) early = 1'b1;
      end
      chk("prio_ls_wall", 32'(wall), 32'd6);
      chk("prio_ls_data", ls_rdata, 32'hDEAD_BEEF);
      chk("prio_ins_early", 32'(early), 32'h0);
      step();
      chk("prio_ls_clear", 32'(ls_done), 32'h0);
      ls_req = 1'b0;
      wall = 0; got = 1'b0;
      while (!got && wall < 50) begin
         step(); wall++;
         if (ins_done) got = 1'b1;
      end
      chk("prio_ins_wall", 32'(wall), 32'd6);
      chk("prio_ins_data", ins, 32'h0010_0513);
      settle("prio");

      // Flush two cycles into a fetch, then a byte load proves the FSM is idle.
      ins_req = 1'b1; ins_addr = 32'h100;
      step(); step();
      jp_wrong = 1'b1;
      step();
      jp_wrong = 1'b0; ins_req = 1'b0;
      run_txn(tab[1], 0, 0, -1, 1'b0, "flush_after");
      bad = 0;
      repeat (6) begin step(); if (ins_done) bad++; end
      chk("flush_no_ins_done", 32'(bad), 32'h0);

      // Flush during a word store is ignored.
      run_txn(mk(1'b0, 1'b1, 2'd2, 32'h400, 32'h1122_3344, 32'h0, 4), 0, 0, 2, 1'b0, "jp_store");
      run_txn(mk(1'b0, 1'b0, 2'd2, 32'h400, 32'h0, 32'h1122_3344, 5), 0, 0, -1, 1'b0, "jp_store_rd");

      // IO store held off while the UART buffer is full.
      ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h3_0000; ls_size = 2'd0; ls_wdata = 32'h5A;
      io_buffer_full = 1'b1;
      bad = 0;
      repeat (3) begin step(); if (mem_wr || ls_done) bad++; end
      chk("io_stall_idle", 32'(bad), 32'h0);
      io_buffer_full = 1'b0;
      step();
      chk("io_accept_wr", 32'(mem_wr), 32'h1);
      chk("io_accept_a", mem_a, 32'h3_0000);
      chk("io_accept_dout", {24'h0, mem_dout}, 32'h5A);
      step();
      chk("io_done", 32'(ls_done), 32'h1);
      chk("io_wr_low", 32'(mem_wr), 32'h0);
      settle("io");

      // rdy low for two cycles mid-fetch stretches latency by two.
      run_txn(tab[0], 2, 2, -1, 1'b0, "rdy_stall");

      // Asynchronous reset during a store drops mem_wr without a clock.
      ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h500; ls_size = 2'd2; ls_wdata = 32'hCAFE_F00D;
      step(); step();
      chk("arst_pre_wr", 32'(mem_wr), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("arst_wr", 32'(mem_wr), 32'h0);
      chk("arst_mem_a", mem_a, 32'h0);
      ls_req = 1'b0; ls_wr = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      // Randomized traffic against the byte-array model.
      for (int i = 0; i < 256; i++) poke(32'hF00 + 32'(i), 8'($urandom));
      for (int i = 0; i < 4; i++) poke(32'hFFFF_FFFC + 32'(i), 8'($urandom));
      for (int i = 0; i < 150; i++) begin
         t.is_ins = ($urandom_range(0, 3) == 0);
         t.wr     = !t.is_ins && ($urandom_range(0, 1) == 1);
         t.size   = 2'($urandom_range(0, 3));
         t.addr   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'h0000_0F00 + 32'($urandom_range(0, 255));
         t.wdata  = $urandom;
         t.exp    = t.wr ? 32'h0 : model_read(t.addr, nbytes_of(t));
         t.lat    = t.wr ? nbytes_of(t) : nbytes_of(t) + 1;
         jp = (t.wr && $urandom_range(0, 2) == 0) ? $urandom_range(1, nbytes_of(t)) : -1;
         run_txn(t, 0, 0, jp, (jp < 0), $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
